// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch/sequencer stage that owns the PC and the link register.
// It fetches one 16-bit instruction over a req/valid handshake, holds it for one
// decode phase, then takes the decoder's branchSel/lr_we to choose the next PC.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   imem_req/addr    - fetch request and address (addr is always pc)
//   imem_valid/rdata - fetch response, sampled only while fetching
//   op, instr        - latched instruction word and its opcode field
//   instr_valid      - high throughout the decode phase
//   pc, lr           - current instruction address, link register
//   branchSel, lr_we - next-PC select and link write, used when leaving decode
//   stall            - holds the current instruction in decode
//   retired          - wrapping count of instructions that left decode
module instr_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_rdata,
    output logic [3:0]        op,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] lr,
    input  logic [1:0]        branchSel,
    input  logic              lr_we,
    input  logic              stall,
    output logic [15:0]       retired
);
    typedef enum logic [1:0] {IDLE, FETCH, DECODE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, lr_q, lr_d, pc_inc;
    logic [15:0]       instr_q, instr_d, retired_q, retired_d;
    logic [11:0]       tgt;
    assign pc_inc = pc_q + ADDR_W'(2);
    // Branch target is the halfword-aligned 12-bit field, resized to the PC width.
    assign tgt = {instr_q[11:1], 1'b0};
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        lr_d      = lr_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: if (imem_valid) begin
                instr_d = imem_rdata;
                state_d = DECODE;
            end
            DECODE: if (!stall) begin
                // Both sides read the old lr/pc, so branchSel=2 with lr_we swaps them.
                pc_d      = branchSel == 2'd1 ? ADDR_W'(tgt) : branchSel == 2'd2 ? lr_q : pc_inc;
                lr_d      = lr_we ? pc_inc : lr_q;
                retired_d = retired_q + 16'd1;
                state_d   = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            lr_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            lr_q      <= lr_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end
    assign imem_req    = state_q == FETCH;
    assign instr_valid = state_q == DECODE;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign lr          = lr_q;
    assign instr       = instr_q;
    assign op          = instr_q[15:12];
    assign retired     = retired_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench for instr_fetch_unit against a per-instruction model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_valid = 1'b0, instr_valid, lr_we = 1'b0, stall = 1'b0;
    logic [15:0] imem_addr, imem_rdata = '0, instr, pc, lr, retired;
    logic [3:0]  op;
    logic [1:0]  branch_sel = '0;
    int          checks = 0, errors = 0;
    logic [15:0] ref_pc, ref_lr, ref_ret;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .op(op), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .lr(lr), .branchSel(branch_sel),
        .lr_we(lr_we), .stall(stall), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        ref_pc  = 16'h0000;
        ref_lr  = 16'h0000;
        ref_ret = 16'h0000;
    endtask

    // One full instruction: fetch with 'waits' wait states, 'stalls' stalled decode
    // cycles, then leave decode with bs/we. Called at a negedge while fetching.
    task automatic run_instr(input logic [15:0] data, input int waits, input int stalls,
                             input logic [1:0] bs, input logic we);
        logic [15:0] nxt;
        for (int i = 0; i <= waits; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== ref_pc || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL fetch req/addr/valid: got %b/%h/%b want 1/%h/0", imem_req, imem_addr, instr_valid, ref_pc);
            end
            imem_valid = (i == waits);
            imem_rdata = (i == waits) ? data : 16'($urandom);
            branch_sel = 2'($urandom);
            lr_we      = 1'($urandom);
            stall      = 1'($urandom);
            @(negedge clk);
        end
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        for (int i = 0; i <= stalls; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== data || op !== data[15:12]
                || pc !== ref_pc || retired !== ref_ret) begin
                errors++;
                $display("FAIL decode valid/req/instr/op/pc/ret: got %b/%b/%h/%h/%h/%h want 1/0/%h/%h/%h/%h",
                         instr_valid, imem_req, instr, op, pc, retired, data, data[15:12], ref_pc, ref_ret);
            end
            imem_valid = 1'($urandom);
            stall      = (i < stalls);
            branch_sel = (i < stalls) ? 2'($urandom) : bs;
            lr_we      = (i < stalls) ? 1'($urandom) : we;
            @(negedge clk);
        end
        nxt = bs == 2'd1 ? {4'h0, data[11:1], 1'b0} : bs == 2'd2 ? ref_lr : ref_pc + 16'd2;
        if (we) ref_lr = ref_pc + 16'd2;
        ref_pc  = nxt;
        ref_ret = ref_ret + 16'd1;
        imem_valid = 1'b0;
        stall      = 1'($urandom);
        branch_sel = 2'($urandom);
        lr_we      = 1'($urandom);
        checks++;
        if (pc !== ref_pc || lr !== ref_lr || retired !== ref_ret || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL retire pc/lr/ret/valid/req: got %h/%h/%h/%b/%b want %h/%h/%h/0/1",
                     pc, lr, retired, instr_valid, imem_req, ref_pc, ref_lr, ref_ret);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if (imem_req !== 1'b0 || pc !== 16'h0 || lr !== 16'h0 || instr !== 16'h0 || op !== 4'h0
            || instr_valid !== 1'b0 || retired !== 16'h0) begin
            errors++;
            $display("FAIL reset state: req=%b pc=%h lr=%h instr=%h op=%h v=%b ret=%h want all 0",
                     imem_req, pc, lr, instr, op, instr_valid, retired);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle req: got %b want 0", imem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) run_instr(16'h4000, 0, 0, 2'd0, 1'b0);
        checks++;
        if (retired !== 16'd3 || pc !== 16'h0006) begin
            errors++;
            $display("FAIL sequential ret/pc: got %h/%h want 0003/0006", retired, pc);
        end
    endtask

    task automatic test_branch_link();
        run_instr(16'h0010, 0, 0, 2'd1, 1'b0);
        run_instr(16'hB120, 0, 0, 2'd1, 1'b1);
        checks++;
        if (imem_addr !== 16'h0120 || lr !== 16'h0012) begin
            errors++;
            $display("FAIL branch link addr/lr: got %h/%h want 0120/0012", imem_addr, lr);
        end
        run_instr(16'hC000, 0, 0, 2'd2, 1'b0);
        checks++;
        if (imem_addr !== 16'h0012) begin
            errors++;
            $display("FAIL return addr: got %h want 0012", imem_addr);
        end
    endtask

    task automatic test_wait_stall();
        run_instr(16'($urandom), 3, 5, 2'd0, 1'b0);
    endtask

    task automatic test_wrap();
        force dut.pc_q = 16'hFFFE;
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.pc_q;
        release dut.retired_q;
        ref_pc  = 16'hFFFE;
        ref_ret = 16'hFFFF;
        run_instr(16'h1234, 1, 0, 2'd0, 1'b0);
        checks++;
        if (imem_addr !== 16'h0000 || retired !== 16'h0000) begin
            errors++;
            $display("FAIL wrap addr/ret: got %h/%h want 0000/0000", imem_addr, retired);
        end
    endtask

    task automatic test_swap();
        run_instr(16'h003E, 0, 0, 2'd1, 1'b0);
        run_instr(16'h0100, 0, 0, 2'd1, 1'b1);
        run_instr(16'h2000, 0, 1, 2'd2, 1'b1);
        checks++;
        if (pc !== 16'h0040 || lr !== 16'h0102) begin
            errors++;
            $display("FAIL swap pc/lr: got %h/%h want 0040/0102", pc, lr);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                      2'($urandom), 1'($urandom));
    endtask

    task automatic test_reset_mid_fetch();
        imem_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || pc !== 16'h0 || lr !== 16'h0 || instr_valid !== 1'b0 || retired !== 16'h0) begin
            errors++;
            $display("FAIL mid-fetch reset req/pc/lr/v/ret: got %b/%h/%h/%b/%h want 0/0000/0000/0/0000",
                     imem_req, pc, lr, instr_valid, retired);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL post-reset idle req: got %b want 0", imem_req);
        end
        @(negedge clk);
        run_instr(16'h5000, 0, 0, 2'd0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch_link();
        test_wait_stall();
        test_wrap();
        test_swap();
        test_random();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch/sequencer stage that produces the opcode and branch flag consumed by the instruction decoder. It owns the PC and link register and fetches 16-bit instructions from instruction memory over a req/valid handshake. It presents each instruction for one decode phase, then applies the decoder's branchSel and link-register write enable to pick the next PC. Sits between instruction memory and the decoder/datapath.

Parameters:
ADDR_W, 16, PC/LR/instruction-address width (byte addressed, instructions 2 bytes)
RESET_PC, 0, PC value loaded on reset (bit 0 must be 0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address, equals pc
imem_valid  input  1  imem_rdata valid this cycle
imem_rdata  input  16  fetched instruction word
op  output  4  opcode to decoder, instr[15:12]
instr  output  16  latched instruction word
instr_valid  output  1  instr/op valid, decode phase active
pc  output  ADDR_W  address of the current instruction
lr  output  ADDR_W  link register
branchSel  input  2  from decoder: 0 pc+2, 1 branch target, 2 return to lr, 3 reserved
lr_we  input  1  from decoder (rfwe[3]): write link register
stall  input  1  hold current instruction in decode
retired  output  16  count of instructions leaving decode, wraps

Behaviour:
- One clock domain; every register is reset synchronously by rst.
- Reset values: pc=RESET_PC, lr=0, instr=0, instr_valid=0, imem_req=0, retired=0, state=IDLE. op=instr[15:12] therefore reads 0.
- States: IDLE, FETCH, DECODE.
- IDLE: imem_req=0. Next cycle goes to FETCH unconditionally. IDLE is entered only from reset.
- FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_valid is sampled at the clock edge.
  - If imem_valid=1: instr<=imem_rdata, instr_valid<=1, go to DECODE.
  - Otherwise stay in FETCH indefinitely (unbounded wait states).
  - Zero-wait memory, with imem_valid high in the first FETCH cycle, gives fetch latency of 1 cycle.
- DECODE: imem_req=0, instr_valid=1, instr and op are held stable.
  - stall=1: remain in DECODE; pc, lr, instr and retired are unchanged.
  - stall=0: at the edge, update pc, lr and retired, clear instr_valid, and return to FETCH.
- Next PC on leaving DECODE:
  - branchSel=0: pc+2.
  - branchSel=1: target = zero-extend {instr[11:1],1'b0} to ADDR_W. If ADDR_W<12, truncate to ADDR_W.
  - branchSel=2: current lr.
  - branchSel=3: pc+2.
- Link register: if lr_we=1 on leaving DECODE, lr<=pc+2 (the old pc). If branchSel=2 and lr_we=1 in the same cycle, pc takes the old lr and lr takes the old pc+2 (swap semantics).
- Arithmetic: pc+2 wraps modulo 2^ADDR_W; for example, 0xFFFE wraps to 0x0000. retired wraps at 0xFFFF to 0.
- Minimum instruction period is 2 cycles (FETCH + DECODE) with zero-wait memory.
- imem_valid is ignored outside FETCH. branchSel, lr_we and stall are ignored outside DECODE.
- rst asserted in any state takes priority: next cycle is IDLE with reset values. An outstanding fetch is abandoned, and imem_req drops the cycle after rst is sampled.
- rst held high keeps all outputs at reset values.

Test Plan:
1. Reset and sequential fetch: RESET_PC=0, zero-wait memory returning 0x4000 (op 4), branchSel=0.
   - Required: imem_addr sequence is 0x0000, 0x0002, 0x0004.
   - instr_valid pulses 1 of every 2 cycles.
   - retired reads 3 after three decodes.
2. Branch with link, then return: at pc=0x0010, fetch 0xB120 with branchSel=1, lr_we=1.
   - Required: next fetch at 0x0120, lr=0x0012.
   - Then decode op 12 with branchSel=2: next fetch at 0x0012.
3. Memory wait states and stall:
   - imem_valid delayed 3 cycles: imem_req stays high and imem_addr stays constant for 4 cycles, then instr_valid=1.
   - stall held for 5 cycles in DECODE: instr, pc and retired are unchanged, and there is no new imem_req until stall falls.
4. Wrap-around: pc=0xFFFE, branchSel=0 -> next imem_addr=0x0000. Also preset retired=0xFFFF, complete one decode -> retired=0x0000.
5. Swap: lr=0x0040, pc=0x0100, branchSel=2, lr_we=1 -> pc=0x0040, lr=0x0102.
6. Reset mid-fetch: assert rst during a FETCH wait state.
   - Required: the next cycle shows imem_req=0, pc=RESET_PC, lr=0, instr_valid=0, retired=0.
   - After rst is released, the first fetch is at RESET_PC following one IDLE cycle.
